// File: rtl/aes_cnfg_slave_mc.sv
// AXI4-Lite control slave for the multi-channel AES-CBC datapath: key staging/commit,
// a queued per-channel IV path with valid/ready to the core, and status/error reporting.
module aes_cnfg_slave_mc #(
    parameter int KEY_BITS        = 128,
    parameter int N_CHAN          = 4,
    parameter int IV_FIFO_DEPTH   = 4,
    localparam int CHAN_BITS      = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                 i_aclk,
    input  logic                 i_areset,
    // AXI4-Lite control slave
    input  logic                 i_axi_awvalid,
    output logic                 o_axi_awready,
    input  logic [6:0]           i_axi_awaddr,
    input  logic                 i_axi_wvalid,
    output logic                 o_axi_wready,
    input  logic [63:0]          i_axi_wdata,
    input  logic [7:0]           i_axi_wstrb,
    output logic                 o_axi_bvalid,
    input  logic                 i_axi_bready,
    output logic [1:0]           o_axi_bresp,
    input  logic                 i_axi_arvalid,
    output logic                 o_axi_arready,
    input  logic [6:0]           i_axi_araddr,
    output logic                 o_axi_rvalid,
    input  logic                 i_axi_rready,
    output logic [63:0]          o_axi_rdata,
    output logic [1:0]           o_axi_rresp,
    // Key-expansion interface
    output logic [KEY_BITS-1:0]  o_key_out,
    output logic                 o_key_valid,
    input  logic                 i_key_ready,
    // IV interface
    output logic [127:0]         o_iv_out,
    output logic [CHAN_BITS-1:0] o_iv_dest,
    output logic                 o_iv_valid,
    input  logic                 i_iv_ready
);

    localparam int KEY_WORDS = KEY_BITS / 64;
    localparam int KI_BITS   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int PTR_BITS  = $clog2(IV_FIFO_DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [63:0]          r_key_stage [KEY_WORDS];
    logic [KEY_BITS-1:0]  r_key_out;
    logic                 r_key_valid;
    logic [63:0]          r_iv_lo;
    logic [63:0]          r_iv_hi;
    logic [CHAN_BITS-1:0] r_iv_dest;
    logic                 r_ovf;
    logic                 r_kovw;
    logic [31:0]          r_push_cnt;
    logic [127:0]         r_fifo_iv   [IV_FIFO_DEPTH];
    logic [CHAN_BITS-1:0] r_fifo_dest [IV_FIFO_DEPTH];
    logic [PTR_BITS-1:0]  r_wptr;
    logic [PTR_BITS-1:0]  r_rptr;
    logic [CNT_BITS-1:0]  r_count;
    logic                 r_bvalid;
    logic [1:0]           r_bresp;
    logic                 r_rvalid;
    logic [63:0]          r_rdata;
    logic [1:0]           r_rresp;

    logic                w_wr_fire;
    logic [3:0]          w_wr_word;
    logic                w_wr_is_key;
    logic [63:0]         w_wr_cur;
    logic [63:0]         w_wr_merged;
    logic                w_wr_err;
    logic                w_key_commit;
    logic [KEY_BITS-1:0] w_new_key;
    logic                w_fifo_full;
    logic                w_push_req;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_clear;
    logic                w_dest_ok;
    logic                w_rd_fire;
    logic [3:0]          w_rd_word;
    logic [63:0]         w_rd_data;
    logic                w_rd_err;
    logic [63:0]         w_status;
    logic                w_unused;

    assign w_unused = ^{i_axi_awaddr[2:0], i_axi_araddr[2:0]};

    // Write decode: strobe-merge against the addressed register's current value
    always_comb begin
        w_wr_fire   = i_axi_awvalid && i_axi_wvalid && !r_bvalid;
        w_wr_word   = i_axi_awaddr[6:3];
        w_wr_is_key = w_wr_word < 4'(KEY_WORDS);
        w_wr_cur    = '0;
        if (w_wr_is_key) begin
            w_wr_cur = r_key_stage[w_wr_word[KI_BITS-1:0]];
        end else begin
            case (w_wr_word)
                4'd4:    w_wr_cur = r_iv_lo;
                4'd5:    w_wr_cur = r_iv_hi;
                4'd6:    w_wr_cur = 64'(r_iv_dest);
                default: w_wr_cur = '0;
            endcase
        end
        for (int b = 0; b < 8; b++) begin
            w_wr_merged[8*b +: 8] = i_axi_wstrb[b] ? i_axi_wdata[8*b +: 8] : w_wr_cur[8*b +: 8];
        end
        for (int i = 0; i < KEY_WORDS; i++) begin
            w_new_key[64*i +: 64] = (i == KEY_WORDS - 1) ? w_wr_merged : r_key_stage[i];
        end
        w_key_commit = w_wr_fire && (w_wr_word == 4'(KEY_WORDS - 1));
        w_fifo_full  = r_count == CNT_BITS'(IV_FIFO_DEPTH);
        w_push_req   = w_wr_fire && (w_wr_word == 4'd5);
        w_push       = w_push_req && !w_fifo_full;
        w_pop        = (r_count != '0) && i_iv_ready;
        w_flush      = w_wr_fire && (w_wr_word == 4'd8) && i_axi_wdata[1];
        w_clear      = w_wr_fire && (w_wr_word == 4'd8) && i_axi_wdata[0];
        w_dest_ok    = w_wr_merged < 64'(N_CHAN);
        w_wr_err     = 1'b0;
        if (!w_wr_is_key) begin
            case (w_wr_word)
                4'd4:    w_wr_err = 1'b0;
                4'd5:    w_wr_err = w_fifo_full;
                4'd6:    w_wr_err = !w_dest_ok;
                4'd8:    w_wr_err = 1'b0;
                default: w_wr_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_status                = '0;
        w_status[0]             = r_key_valid;
        w_status[1]             = r_count == '0;
        w_status[2]             = w_fifo_full;
        w_status[3]             = r_ovf;
        w_status[4]             = r_kovw;
        w_status[8 +: CNT_BITS] = r_count;
    end

    always_comb begin
        w_rd_fire = i_axi_arvalid && !r_rvalid;
        w_rd_word = i_axi_araddr[6:3];
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_rd_word < 4'(KEY_WORDS)) begin
            w_rd_data = r_key_stage[w_rd_word[KI_BITS-1:0]];
        end else begin
            case (w_rd_word)
                4'd4:    w_rd_data = r_iv_lo;
                4'd5:    w_rd_data = r_iv_hi;
                4'd6:    w_rd_data = 64'(r_iv_dest);
                4'd7:    w_rd_data = w_status;
                4'd8:    w_rd_data = '0;
                4'd9:    w_rd_data = {32'b0, r_push_cnt};
                default: w_rd_err  = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_bvalid && i_axi_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_rvalid && i_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int i = 0; i < KEY_WORDS; i++) r_key_stage[i] <= '0;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_iv_lo     <= '0;
            r_iv_hi     <= '0;
            r_iv_dest   <= '0;
            r_ovf       <= 1'b0;
            r_kovw      <= 1'b0;
            r_push_cnt  <= '0;
        end else begin
            if (w_wr_fire) begin
                if (w_wr_is_key) r_key_stage[w_wr_word[KI_BITS-1:0]] <= w_wr_merged;
                case (w_wr_word)
                    4'd4:    r_iv_lo <= w_wr_merged;
                    4'd5:    if (!w_fifo_full) r_iv_hi <= w_wr_merged;
                    4'd6:    if (w_dest_ok) r_iv_dest <= w_wr_merged[CHAN_BITS-1:0];
                    default: ;
                endcase
            end
            if (w_key_commit) begin
                r_key_out   <= w_new_key;
                r_key_valid <= 1'b1;
            end else if (r_key_valid && i_key_ready) begin
                r_key_valid <= 1'b0;
            end
            // A clear and a set never coincide: both need a write, one write per cycle
            if (w_clear) begin
                r_ovf  <= 1'b0;
                r_kovw <= 1'b0;
            end else begin
                if (w_push_req && w_fifo_full) r_ovf <= 1'b1;
                if (w_key_commit && r_key_valid && !i_key_ready) r_kovw <= 1'b1;
            end
            if (w_push) r_push_cnt <= r_push_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int i = 0; i < IV_FIFO_DEPTH; i++) begin
                r_fifo_iv[i]   <= '0;
                r_fifo_dest[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_iv[r_wptr]   <= {w_wr_merged, r_iv_lo};
                r_fifo_dest[r_wptr] <= r_iv_dest;
                r_wptr              <= r_wptr + PTR_BITS'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_BITS'(1);
            r_count <= r_count + CNT_BITS'(w_push) - CNT_BITS'(w_pop);
        end
    end

    assign o_axi_awready = w_wr_fire;
    assign o_axi_wready  = w_wr_fire;
    assign o_axi_bvalid  = r_bvalid;
    assign o_axi_bresp   = r_bresp;
    assign o_axi_arready = w_rd_fire;
    assign o_axi_rvalid  = r_rvalid;
    assign o_axi_rdata   = r_rdata;
    assign o_axi_rresp   = r_rresp;
    assign o_key_out     = r_key_out;
    assign o_key_valid   = r_key_valid;
    assign o_iv_valid    = r_count != '0;
    assign o_iv_out      = o_iv_valid ? r_fifo_iv[r_rptr] : '0;
    assign o_iv_dest     = o_iv_valid ? r_fifo_dest[r_rptr] : '0;

endmodule

// File: tb/tb_aes_cnfg_slave_mc.sv
// Scoreboard bench for aes_cnfg_slave_mc (KEY_BITS=256, N_CHAN=4, IV_FIFO_DEPTH=4).
module tb_aes_cnfg_slave_mc;

    localparam int KEY_BITS = 256;
    localparam int N_CHAN   = 4;
    localparam int DEPTH    = 4;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;
    localparam logic [3:0] W_IVLO = 4'd4, W_IVHI = 4'd5, W_DEST = 4'd6;
    localparam logic [3:0] W_STAT = 4'd7, W_CTRL = 4'd8, W_PCNT = 4'd9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [6:0]    awaddr, araddr;
    logic [63:0]   wdata, rdata;
    logic [7:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;
    logic [KEY_BITS-1:0] key_out;
    logic          key_valid, key_ready;
    logic [127:0]  iv_out;
    logic [1:0]    iv_dest;
    logic          iv_valid, iv_ready;

    aes_cnfg_slave_mc #(
        .KEY_BITS      (KEY_BITS),
        .N_CHAN        (N_CHAN),
        .IV_FIFO_DEPTH (DEPTH)
    ) dut (
        .i_aclk        (clk),
        .i_areset      (rst),
        .i_axi_awvalid (awvalid),
        .o_axi_awready (awready),
        .i_axi_awaddr  (awaddr),
        .i_axi_wvalid  (wvalid),
        .o_axi_wready  (wready),
        .i_axi_wdata   (wdata),
        .i_axi_wstrb   (wstrb),
        .o_axi_bvalid  (bvalid),
        .i_axi_bready  (bready),
        .o_axi_bresp   (bresp),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (arready),
        .i_axi_araddr  (araddr),
        .o_axi_rvalid  (rvalid),
        .i_axi_rready  (rready),
        .o_axi_rdata   (rdata),
        .o_axi_rresp   (rresp),
        .o_key_out     (key_out),
        .o_key_valid   (key_valid),
        .i_key_ready   (key_ready),
        .o_iv_out      (iv_out),
        .o_iv_dest     (iv_dest),
        .o_iv_valid    (iv_valid),
        .i_iv_ready    (iv_ready)
    );

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // pop=1 holds iv_ready high across the write handshake edge
    task automatic axi_write(input string tag, input logic [3:0] word, input logic [63:0] data,
                             input logic [7:0] strb, input logic [1:0] exp_resp, input logic pop);
        exp_t e;
        int   n;
        e.tag = tag; e.data = '0; e.resp = exp_resp;
        sb_q.push_back(e);
        awaddr = {word, 3'b000}; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; iv_ready = pop;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        if (!(awready && wready)) begin
            check({e.tag, "_aw_timeout"}, 256'(0), 256'(1));
            awvalid = 1'b0; wvalid = 1'b0; iv_ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; iv_ready = 1'b0; bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) check({e.tag, "_b_timeout"}, 256'(0), 256'(1));
        else         check({e.tag, "_bresp"}, 256'(bresp), 256'(e.resp));
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [3:0] word,
                            input logic [63:0] exp_data, input logic [1:0] exp_resp);
        exp_t e;
        int   n;
        e.tag = tag; e.data = exp_data; e.resp = exp_resp;
        sb_q.push_back(e);
        araddr = {word, 3'b000}; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        e = sb_q.pop_front();
        if (!arready) begin
            check({e.tag, "_ar_timeout"}, 256'(0), 256'(1));
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) begin
            check({e.tag, "_r_timeout"}, 256'(0), 256'(1));
        end else begin
            check({e.tag, "_rdata"}, 256'(rdata), 256'(e.data));
            check({e.tag, "_rresp"}, 256'(rresp), 256'(e.resp));
        end
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        key_ready = 0; iv_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        tick();

        // Reset state
        check("rst_key_valid", 256'(key_valid), 256'(0));
        check("rst_key_out", key_out, 256'(0));
        check("rst_iv_valid", 256'(iv_valid), 256'(0));
        check("rst_bvalid", 256'(bvalid), 256'(0));
        check("rst_rvalid", 256'(rvalid), 256'(0));
        axi_read("rst_status", W_STAT, 64'h2, OK);

        // Key staging and commit
        axi_write("k_w0", 4'd0, {16{4'h1}}, 8'hFF, OK, 1'b0);
        axi_write("k_w1", 4'd1, {16{4'h2}}, 8'hFF, OK, 1'b0);
        axi_write("k_w2", 4'd2, {16{4'h3}}, 8'hFF, OK, 1'b0);
        check("k_valid_pre", 256'(key_valid), 256'(0));
        axi_write("k_w3", 4'd3, {16{4'h4}}, 8'hFF, OK, 1'b0);
        check("k_valid", 256'(key_valid), 256'(1));
        check("k_out", key_out, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        axi_write("k_ovw", 4'd3, {16{4'h5}}, 8'hFF, OK, 1'b0);
        check("k_out_ovw", key_out, {{16{4'h5}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        axi_read("k_stat_ovw", W_STAT, 64'h13, OK);
        key_ready = 1'b1; tick(); key_ready = 1'b0;
        check("k_valid_drop", 256'(key_valid), 256'(0));
        axi_write("k_clr", W_CTRL, 64'h1, 8'hFF, OK, 1'b0);
        axi_read("k_stat_clr", W_STAT, 64'h2, OK);
        axi_write("k_strb", 4'd0, {16{4'hF}}, 8'h0F, OK, 1'b0);
        axi_read("k_strb_rd", 4'd0, 64'h1111_1111_FFFF_FFFF, OK);

        // Single IV push
        axi_write("iv_dest", W_DEST, 64'd2, 8'hFF, OK, 1'b0);
        axi_write("iv_lo", W_IVLO, 64'hA, 8'hFF, OK, 1'b0);
        axi_write("iv_hi", W_IVHI, 64'hB, 8'hFF, OK, 1'b0);
        check("iv_valid", 256'(iv_valid), 256'(1));
        check("iv_out", 256'(iv_out), 256'({64'hB, 64'hA}));
        check("iv_dest_out", 256'(iv_dest), 256'(2));
        axi_read("iv_stat", W_STAT, 64'h100, OK);
        axi_read("iv_pcnt", W_PCNT, 64'd1, OK);

        // Fill to full, then overflow
        for (int i = 0; i < 3; i++) begin
            axi_write("fill", W_IVHI, 64'(4'hC + i), 8'hFF, OK, 1'b0);
        end
        axi_write("ovf_push", W_IVHI, 64'hF, 8'hFF, ERR, 1'b0);
        axi_read("ovf_stat", W_STAT, 64'h40C, OK);
        axi_read("ovf_pcnt", W_PCNT, 64'd4, OK);
        axi_read("ovf_ivhi", W_IVHI, 64'hE, OK);
        check("ovf_head", 256'(iv_out), 256'({64'hB, 64'hA}));
        axi_write("ovf_clr", W_CTRL, 64'h1, 8'hFF, OK, 1'b0);
        axi_read("ovf_stat_clr", W_STAT, 64'h404, OK);

        // Push to full FIFO while a pop happens in the same cycle
        axi_write("full_pop", W_IVHI, 64'h99, 8'hFF, ERR, 1'b1);
        axi_read("full_pop_stat", W_STAT, 64'h308, OK);
        check("full_pop_head", 256'(iv_out), 256'({64'hC, 64'hA}));
        iv_ready = 1'b1; tick(); iv_ready = 1'b0;
        check("pop_head", 256'(iv_out), 256'({64'hD, 64'hA}));

        // Error responses
        axi_read("unmapped_rd", 4'hF, 64'h0, ERR);
        axi_write("dest_bad", W_DEST, 64'(N_CHAN), 8'hFF, ERR, 1'b0);
        axi_read("dest_keep", W_DEST, 64'd2, OK);
        axi_write("stat_wr", W_STAT, 64'hFF, 8'hFF, ERR, 1'b0);
        axi_read("ctrl_rd", W_CTRL, 64'h0, OK);

        // Async reset with a write response pending and two IVs queued
        axi_read("pre_rst_stat", W_STAT, 64'h208, OK);
        awaddr = {W_IVLO, 3'b000}; wdata = 64'h77; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("pre_rst_bvalid", 256'(bvalid), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_bvalid", 256'(bvalid), 256'(0));
        check("arst_key_out", key_out, 256'(0));
        check("arst_iv_valid", 256'(iv_valid), 256'(0));
        check("arst_iv_out", 256'(iv_out), 256'(0));
        check("arst_iv_dest", 256'(iv_dest), 256'(0));
        @(negedge clk); rst = 1'b0;
        tick();
        axi_read("post_rst_stat", W_STAT, 64'h2, OK);
        axi_read("post_rst_ivlo", W_IVLO, 64'h0, OK);
        axi_read("post_rst_pcnt", W_PCNT, 64'h0, OK);

        // Flush
        axi_write("fl_dest", W_DEST, 64'd1, 8'hFF, OK, 1'b0);
        axi_write("fl_p1", W_IVHI, 64'h1, 8'hFF, OK, 1'b0);
        axi_write("fl_p2", W_IVHI, 64'h2, 8'hFF, OK, 1'b0);
        check("fl_dest_out", 256'(iv_dest), 256'(1));
        axi_read("fl_stat_pre", W_STAT, 64'h200, OK);
        axi_write("fl_ctrl", W_CTRL, 64'h2, 8'hFF, OK, 1'b0);
        check("fl_iv_valid", 256'(iv_valid), 256'(0));
        axi_read("fl_stat", W_STAT, 64'h2, OK);
        axi_read("fl_pcnt", W_PCNT, 64'd2, OK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
